// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: stall/flush for F/D/E/M, launch and timing of the iterative
// mult/div unit, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 12,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       writereg_E,
    input  logic             regwrite_E,
    input  logic             memtoreg_E,
    input  logic [4:0]       writereg_M,
    input  logic             memtoreg_M,
    input  logic             branch_D,
    input  logic             jr_D,
    input  logic             mfhilo_D,
    input  logic             md_req_E,
    input  logic             md_div_E,
    input  logic             perf_clr,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             flush_E,
    output logic             flush_M,
    output logic             md_start,
    output logic             md_busy,
    output logic             hilo_we,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The counter holds remaining BUSY cycles minus one, so the load value is LAT-2.
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 2);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 2);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic e_rs_hit, e_rt_hit, m_rs_hit, m_rt_hit;
    logic lwstall, brstall, hlstall_D, mdstall_E;
    logic state_busy, start_w, stall_w;

    always_comb begin
        e_rs_hit = (writereg_E != 5'd0) && (writereg_E == rs_D);
        e_rt_hit = (writereg_E != 5'd0) && (writereg_E == rt_D);
        m_rs_hit = (writereg_M != 5'd0) && (writereg_M == rs_D);
        m_rt_hit = (writereg_M != 5'd0) && (writereg_M == rt_D);
    end

    always_comb begin
        state_busy = (state_q == S_BUSY);
        start_w    = md_req_E & ~state_busy;
        lwstall    = memtoreg_E & (e_rs_hit | e_rt_hit);
        brstall    = (branch_D & ((regwrite_E & (e_rs_hit | e_rt_hit)) |
                                  (memtoreg_M & (m_rs_hit | m_rt_hit)))) |
                     (jr_D & ((regwrite_E & e_rs_hit) | (memtoreg_M & m_rs_hit)));
        // In DONE the HI/LO write lands on this edge, so mfhi/mflo may proceed.
        hlstall_D  = mfhilo_D & (state_busy | start_w);
        mdstall_E  = md_req_E & state_busy;
        stall_w    = lwstall | brstall | hlstall_D | mdstall_E;
    end

    // Combinational outputs are forced low while reset is held.
    always_comb begin
        stall_F  = stall_w & ~reset;
        stall_D  = stall_w & ~reset;
        stall_E  = mdstall_E & ~reset;
        flush_M  = mdstall_E & ~reset;
        flush_E  = (lwstall | brstall | hlstall_D) & ~mdstall_E & ~reset;
        md_start = start_w & ~reset;
        md_busy  = state_busy;
        hilo_we  = (state_q == S_DONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A launch can only occur outside BUSY, so it overrides the plain transitions.
        if (start_w) begin
            state_d = S_BUSY;
            cnt_d   = md_div_E ? DIV_LOAD : MULT_LOAD;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl against a timestamp-based reference model.
module tb_hazard_stall_ctrl;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 12;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rs_D, rt_D, writereg_E, writereg_M;
    logic             regwrite_E, memtoreg_E, memtoreg_M;
    logic             branch_D, jr_D, mfhilo_D, md_req_E, md_div_E, perf_clr;
    logic             stall_F, stall_D, stall_E, flush_E, flush_M;
    logic             md_start, md_busy, hilo_we;
    logic [CNT_W-1:0] stall_cnt;

    hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .writereg_E(writereg_E), .regwrite_E(regwrite_E),
        .memtoreg_E(memtoreg_E), .writereg_M(writereg_M), .memtoreg_M(memtoreg_M),
        .branch_D(branch_D), .jr_D(jr_D), .mfhilo_D(mfhilo_D),
        .md_req_E(md_req_E), .md_div_E(md_div_E), .perf_clr(perf_clr),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .flush_E(flush_E), .flush_M(flush_M),
        .md_start(md_start), .md_busy(md_busy), .hilo_we(hilo_we),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: an operation in flight is just the absolute cycle its HI/LO write is due.
    bit m_active  = 1'b0;
    int m_done_at = 0;
    int m_cnt     = 0;

    int s_stall_F, s_stall_D, s_stall_E, s_flush_E, s_flush_M;
    int s_md_start, s_md_busy, s_hilo_we, s_stall_cnt;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    function automatic bit hit(input logic [4:0] w, input logic [4:0] r);
        return (w != 5'd0) && (w == r);
    endfunction

    task automatic step();
        bit busy, done, lw, br, hl, mdst, start, stall;
        int e_sf, e_se, e_fe, e_fm, e_ms, e_mb, e_hw, e_cnt;
        @(negedge clk);
        s_stall_F = stall_F;   s_stall_D = stall_D;   s_stall_E = stall_E;
        s_flush_E = flush_E;   s_flush_M = flush_M;   s_md_start = md_start;
        s_md_busy = md_busy;   s_hilo_we = hilo_we;   s_stall_cnt = int'(stall_cnt);
        e_sf = 0; e_se = 0; e_fe = 0; e_fm = 0; e_ms = 0; e_mb = 0; e_hw = 0; e_cnt = 0;
        start = 1'b0; done = 1'b0; stall = 1'b0;
        if (!reset) begin
            busy  = m_active && (cyc < m_done_at);
            done  = m_active && (cyc == m_done_at);
            lw    = memtoreg_E && (hit(writereg_E, rs_D) || hit(writereg_E, rt_D));
            br    = (branch_D && ((regwrite_E && (hit(writereg_E, rs_D) || hit(writereg_E, rt_D))) ||
                                  (memtoreg_M && (hit(writereg_M, rs_D) || hit(writereg_M, rt_D))))) ||
                    (jr_D && ((regwrite_E && hit(writereg_E, rs_D)) ||
                              (memtoreg_M && hit(writereg_M, rs_D))));
            start = md_req_E && !busy;
            mdst  = md_req_E && busy;
            hl    = mfhilo_D && (busy || start);
            stall = lw || br || hl || mdst;
            e_sf  = int'(stall);
            e_se  = int'(mdst);
            e_fm  = int'(mdst);
            e_fe  = int'((lw || br || hl) && !mdst);
            e_ms  = int'(start);
            e_mb  = int'(busy);
            e_hw  = int'(done);
            e_cnt = m_cnt;
        end
        chk("stall_F", s_stall_F, e_sf);
        chk("stall_D", s_stall_D, e_sf);
        chk("stall_E", s_stall_E, e_se);
        chk("flush_E", s_flush_E, e_fe);
        chk("flush_M", s_flush_M, e_fm);
        chk("md_start", s_md_start, e_ms);
        chk("md_busy", s_md_busy, e_mb);
        chk("hilo_we", s_hilo_we, e_hw);
        chk("stall_cnt", s_stall_cnt, e_cnt);
        if (reset) begin
            m_active = 1'b0;
            m_cnt    = 0;
        end else begin
            if (start) begin
                m_active  = 1'b1;
                m_done_at = cyc + (md_div_E ? DIV_LAT : MULT_LAT);
            end else if (done) begin
                m_active = 1'b0;
            end
            if (perf_clr)                       m_cnt = 0;
            else if (stall && m_cnt < CNT_MAX)  m_cnt = m_cnt + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs_D = 5'd0; rt_D = 5'd0; writereg_E = 5'd0; writereg_M = 5'd0;
        regwrite_E = 1'b0; memtoreg_E = 1'b0; memtoreg_M = 1'b0;
        branch_D = 1'b0; jr_D = 1'b0; mfhilo_D = 1'b0;
        md_req_E = 1'b0; md_div_E = 1'b0; perf_clr = 1'b0;
    endtask

    initial begin
        int hw_seen;
        reset = 1'b1;
        set_idle();
        repeat (3) step();
        chk("rst_stall_F", s_stall_F, 0);
        chk("rst_md_busy", s_md_busy, 0);
        chk("rst_stall_cnt", s_stall_cnt, 0);
        reset = 1'b0;
        step();

        // load-use
        memtoreg_E = 1'b1; regwrite_E = 1'b1; writereg_E = 5'd8; rs_D = 5'd8;
        step();
        chk("lw_stall_F", s_stall_F, 1);
        chk("lw_stall_D", s_stall_D, 1);
        chk("lw_flush_E", s_flush_E, 1);
        chk("lw_stall_E", s_stall_E, 0);
        writereg_E = 5'd0; rs_D = 5'd0;
        step();
        chk("lw_r0_stall_F", s_stall_F, 0);
        chk("cnt_after_lw", s_stall_cnt, 1);

        // branch operand from E, then from a load in M
        set_idle();
        branch_D = 1'b1; rs_D = 5'd5; rt_D = 5'd9; regwrite_E = 1'b1; writereg_E = 5'd5;
        step();
        chk("br_E_stall_F", s_stall_F, 1);
        chk("br_E_flush_E", s_flush_E, 1);
        regwrite_E = 1'b0; writereg_E = 5'd0; memtoreg_M = 1'b1; writereg_M = 5'd5;
        step();
        chk("br_M_stall_F", s_stall_F, 1);
        set_idle();
        step();
        chk("br_clear_stall_F", s_stall_F, 0);

        // mult with mflo waiting in D
        md_req_E = 1'b1; md_div_E = 1'b0; mfhilo_D = 1'b1;
        step();
        chk("mul_md_start", s_md_start, 1);
        chk("mul_busy0", s_md_busy, 0);
        chk("mul_hl_stall_D", s_stall_D, 1);
        chk("mul_hl_flush_E", s_flush_E, 1);
        md_req_E = 1'b0;
        for (int i = 1; i < MULT_LAT; i++) begin
            step();
            chk("mul_busy", s_md_busy, 1);
            chk("mul_hl_hold", s_stall_D, 1);
            chk("mul_no_hilo", s_hilo_we, 0);
        end
        step();
        chk("mul_hilo_we", s_hilo_we, 1);
        chk("mul_hl_release", s_stall_D, 0);
        chk("mul_busy_end", s_md_busy, 0);
        mfhilo_D = 1'b0;
        step();
        chk("mul_hilo_once", s_hilo_we, 0);

        // single div
        md_req_E = 1'b1; md_div_E = 1'b1;
        step();
        chk("div_md_start", s_md_start, 1);
        md_req_E = 1'b0;
        for (int i = 1; i < DIV_LAT; i++) begin
            step();
            chk("div_no_hilo", s_hilo_we, 0);
        end
        step();
        chk("div_hilo_we", s_hilo_we, 1);

        // back-to-back div: the second one waits in E
        md_req_E = 1'b1; md_div_E = 1'b1;
        step();
        chk("b2b_start1", s_md_start, 1);
        for (int i = 1; i < DIV_LAT; i++) begin
            step();
            chk("b2b_stall_E", s_stall_E, 1);
            chk("b2b_flush_M", s_flush_M, 1);
            chk("b2b_flush_E", s_flush_E, 0);
            chk("b2b_no_start", s_md_start, 0);
        end
        step();
        chk("b2b_hilo_we", s_hilo_we, 1);
        chk("b2b_start2", s_md_start, 1);
        chk("b2b_stall_E_rel", s_stall_E, 0);
        md_req_E = 1'b0;
        step();
        chk("b2b_busy2", s_md_busy, 1);
        step();
        step();

        // reset mid-div with hazards present on the inputs
        reset = 1'b1;
        memtoreg_E = 1'b1; writereg_E = 5'd8; rs_D = 5'd8; md_req_E = 1'b1; mfhilo_D = 1'b1;
        step();
        chk("mid_rst_stall_F", s_stall_F, 0);
        chk("mid_rst_md_start", s_md_start, 0);
        chk("mid_rst_md_busy", s_md_busy, 0);
        chk("mid_rst_stall_cnt", s_stall_cnt, 0);
        reset = 1'b0;
        set_idle();
        hw_seen = 0;
        for (int i = 0; i < DIV_LAT + 3; i++) begin
            step();
            hw_seen += s_hilo_we;
        end
        chk("mid_rst_no_hilo", hw_seen, 0);

        // counter saturation, then clear while stalling
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0; memtoreg_E = 1'b1; writereg_E = 5'd8; rs_D = 5'd8;
        repeat (CNT_MAX + 4) step();
        chk("cnt_saturated", s_stall_cnt, 16'hFFFF);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        step();
        chk("cnt_clr_wins", s_stall_cnt, 0);
        step();
        chk("cnt_after_clr", s_stall_cnt, 1);

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            rs_D       = 5'($urandom_range(0, 3));
            rt_D       = 5'($urandom_range(0, 3));
            writereg_E = 5'($urandom_range(0, 3));
            writereg_M = 5'($urandom_range(0, 3));
            regwrite_E = 1'($urandom_range(0, 1));
            memtoreg_E = ($urandom_range(0, 3) == 0);
            memtoreg_M = ($urandom_range(0, 3) == 0);
            branch_D   = ($urandom_range(0, 3) == 0);
            jr_D       = ($urandom_range(0, 5) == 0);
            mfhilo_D   = ($urandom_range(0, 3) == 0);
            md_req_E   = ($urandom_range(0, 3) == 0);
            md_div_E   = 1'($urandom_range(0, 1));
            perf_clr   = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
